// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard and forwarding controller.
// Tracks destination registers of the EX, MEM and WB stages, picks the
// youngest producer for each source operand, and raises load-use stalls
// and memory-wait freezes.
// Optional build macro: HAZARD_PERF_EN adds perf_lu_stalls / perf_fwd_cnt.
module id_hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic [DATA_W-1:0] rf_src1,
    input  logic [DATA_W-1:0] rf_src2,
    input  logic [DATA_W-1:0] ex_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_wait,
    input  logic              flush,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_lu_stalls,
    output logic [31:0]       perf_fwd_cnt
`endif
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } slot_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    slot_t  ex_q, mem_q, wb_q;
    state_t state_q, state_d;

    logic       load_use;
    logic [1:0] sel1_raw, sel2_raw;

    function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] rs,
                                        input logic used);
        return s.v && s.we && (s.rd == rs) && (rs != '0) && used;
    endfunction

    // Youngest producer wins: EX, then MEM, then WB, else register file.
    function automatic logic [1:0] pick_src(input slot_t se, input slot_t sm, input slot_t sw,
                                            input logic [REG_AW-1:0] rs, input logic used);
        if (slot_match(se, rs, used))      return SEL_EX;
        else if (slot_match(sm, rs, used)) return SEL_MEM;
        else if (slot_match(sw, rs, used)) return SEL_WB;
        else                               return SEL_RF;
    endfunction

    // Operand source selection, hazard detection and stall/bubble outputs.
    always_comb begin
        sel1_raw = pick_src(ex_q, mem_q, wb_q, id_rs1, id_rs1_used);
        sel2_raw = pick_src(ex_q, mem_q, wb_q, id_rs2, id_rs2_used);

        load_use = id_valid && !flush && ex_q.ld &&
                   (slot_match(ex_q, id_rs1, id_rs1_used) ||
                    slot_match(ex_q, id_rs2, id_rs2_used));

        // Reset overrides the handshake outputs so ID/EX is loaded with NOPs.
        stall_id  = rst && (load_use || mem_wait);
        bubble_ex = !rst || ((load_use || flush) && !mem_wait);
        fwd_sel1  = rst ? sel1_raw : SEL_RF;
        fwd_sel2  = rst ? sel2_raw : SEL_RF;

        unique case (fwd_sel1)
            SEL_EX:  src1 = ex_data;
            SEL_MEM: src1 = mem_data;
            SEL_WB:  src1 = wb_data;
            default: src1 = rf_src1;
        endcase
        unique case (fwd_sel2)
            SEL_EX:  src2 = ex_data;
            SEL_MEM: src2 = mem_data;
            SEL_WB:  src2 = wb_data;
            default: src2 = rf_src2;
        endcase
    end

    // Next-state logic: memory wait dominates, a load-use stall lasts one cycle.
    always_comb begin
        state_d = state_q;
        if (mem_wait) begin
            state_d = MEM_WAIT;
        end else begin
            unique case (state_q)
                RUN:      state_d = load_use ? LU_STALL : RUN;
                LU_STALL: state_d = RUN;
                MEM_WAIT: state_d = load_use ? LU_STALL : RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    // Scoreboard shift; frozen while memory is busy (flush is ignored then).
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_wait) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (bubble_ex || !id_valid) begin
                ex_q <= '0;
            end else begin
                ex_q.v  <= 1'b1;
                ex_q.rd <= id_rd;
                ex_q.we <= id_rd_we;
                ex_q.ld <= id_is_load;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating counters: LU_STALL cycles, and issuing cycles that consume a forwarded operand.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_lu_stalls <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (state_q == LU_STALL && perf_lu_stalls != '1)
                perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (id_valid && !stall_id && (fwd_sel1 != SEL_RF || fwd_sel2 != SEL_RF) &&
                perf_fwd_cnt != '1)
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
        end
    end
`endif

endmodule
